// File: rtl/mem_bus_master_if.sv
// Request/response handshake and memory control signals of the memory bus master.
// The tri-state data bus stays a plain inout port on the master.
interface mem_bus_master_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              REQ;
  logic              REQ_WE;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_WDATA;
  logic              BUSY;
  logic              DONE;
  logic [DATA_W-1:0] RDATA;
  logic              ERR;
  logic              CS;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;

  modport master (
    input  REQ, REQ_WE, REQ_ADDR, REQ_WDATA,
    output BUSY, DONE, RDATA, ERR, CS, WE, ADDR
  );

  modport slave (
    output REQ, REQ_WE, REQ_ADDR, REQ_WDATA,
    input  BUSY, DONE, RDATA, ERR, CS, WE, ADDR
  );
endinterface

// File: rtl/mem_bus_master.sv
// Initiator for the shared single-port memory bus (negedge-sampling memory).
// Optional macro MEM_BUS_READBACK_VERIFY_EN adds an automatic readback after every write.
module mem_bus_master #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  mem_bus_master_if.master   bus,
  inout  wire  [DATA_W-1:0]  Mem_Bus
);

  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0]  WAIT_CNT = CNT_W'(WAIT_CYCLES);

`ifdef MEM_BUS_READBACK_VERIFY_EN
  typedef enum logic [1:0] {IDLE, ACCESS, TURN, VERIFY} state_e;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_e;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef MEM_BUS_READBACK_VERIFY_EN
  logic              err_q, err_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_BUS_READBACK_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_BUS_READBACK_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (bus.REQ) state_d = ACCESS;
      ACCESS: if (cnt_q == '0) state_d = we_q ? TURN : IDLE;
`ifdef MEM_BUS_READBACK_VERIFY_EN
      TURN:   state_d = VERIFY;
      VERIFY: if (cnt_q == '0) state_d = IDLE;
`else
      TURN:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered bus outputs and the datapath.
  always_comb begin
    cs_d    = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_BUS_READBACK_VERIFY_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.REQ) begin
          cs_d    = 1'b1;
          we_d    = bus.REQ_WE;
          addr_d  = bus.REQ_ADDR;
          wdata_d = bus.REQ_WDATA;
          cnt_d   = WAIT_CNT;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cs_d  = 1'b1;
          we_d  = we_q;
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!we_q) begin
          rdata_d = Mem_Bus;
          done_d  = 1'b1;
        end
      end
`ifdef MEM_BUS_READBACK_VERIFY_EN
      TURN: begin
        cs_d  = 1'b1;
        cnt_d = WAIT_CNT;
      end
      VERIFY: begin
        if (cnt_q != '0) begin
          cs_d  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rdata_d = Mem_Bus;
          done_d  = 1'b1;
          err_d   = err_q | (Mem_Bus != wdata_q);
        end
      end
`else
      TURN: done_d = 1'b1;
`endif
      default: ;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  // Drive enable comes only from registers, so reset releases the bus at once.
  assign Mem_Bus = (cs_q && we_q) ? wdata_q : {DATA_W{1'bz}};

  assign bus.CS    = cs_q;
  assign bus.WE    = we_q;
  assign bus.ADDR  = addr_q;
  assign bus.DONE  = done_q;
  assign bus.BUSY  = busy_q;
  assign bus.RDATA = rdata_q;
`ifdef MEM_BUS_READBACK_VERIFY_EN
  assign bus.ERR   = err_q;
`else
  assign bus.ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench: two masters (WAIT_CYCLES 0 and 3), each on its own negedge memory model,
// checked against an array-based reference of memory contents and access timing.
module tb_mem_bus_master;
  localparam int AW   = 7;
  localparam int DW   = 32;
  localparam int NDUT = 2;
`ifdef MEM_BUS_READBACK_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  mem_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  wire [DW-1:0] mem_bus0;
  wire [DW-1:0] mem_bus1;

  mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus0), .Mem_Bus(mem_bus0));
  mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus1), .Mem_Bus(mem_bus1));

  logic          req [NDUT];
  logic          req_we [NDUT];
  logic [AW-1:0] req_addr [NDUT];
  logic [DW-1:0] req_wdata [NDUT];
  logic          busy [NDUT], done [NDUT], err [NDUT], cs [NDUT], we [NDUT];
  logic [AW-1:0] addr [NDUT];
  logic [DW-1:0] rdata [NDUT], bus_v [NDUT];

  assign bus0.REQ = req[0];  assign bus0.REQ_WE = req_we[0];
  assign bus0.REQ_ADDR = req_addr[0];  assign bus0.REQ_WDATA = req_wdata[0];
  assign bus1.REQ = req[1];  assign bus1.REQ_WE = req_we[1];
  assign bus1.REQ_ADDR = req_addr[1];  assign bus1.REQ_WDATA = req_wdata[1];
  assign busy[0] = bus0.BUSY;  assign done[0] = bus0.DONE;  assign err[0] = bus0.ERR;
  assign cs[0] = bus0.CS;  assign we[0] = bus0.WE;  assign addr[0] = bus0.ADDR;
  assign rdata[0] = bus0.RDATA;  assign bus_v[0] = mem_bus0;
  assign busy[1] = bus1.BUSY;  assign done[1] = bus1.DONE;  assign err[1] = bus1.ERR;
  assign cs[1] = bus1.CS;  assign we[1] = bus1.WE;  assign addr[1] = bus1.ADDR;
  assign rdata[1] = bus1.RDATA;  assign bus_v[1] = mem_bus1;

  // Memory model: samples/drives on negedge; bit0 can be forced stuck-at-0 on writes.
  logic [DW-1:0] ram [NDUT][128];
  logic [DW-1:0] mem_q [NDUT];
  logic [DW-1:0] model [NDUT][128];
  logic [DW-1:0] last_rd [NDUT];
  bit            load_ram = 1'b0;
  bit            stuck0 = 1'b0;

  always @(negedge CLK) begin
    for (int k = 0; k < NDUT; k++) begin
      if (load_ram) begin
        for (int a = 0; a < 128; a++) ram[k][a] <= model[k][a];
      end else begin
        if (cs[k] && we[k])  ram[k][addr[k]] <= stuck0 ? (bus_v[k] & ~32'd1) : bus_v[k];
        if (cs[k] && !we[k]) mem_q[k] <= ram[k][addr[k]];
      end
    end
  end

  assign mem_bus0 = (cs[0] && !we[0]) ? mem_q[0] : {DW{1'bz}};
  assign mem_bus1 = (cs[1] && !we[1]) ? mem_q[1] : {DW{1'bz}};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // One complete access; timing expectations follow from the wait count and access kind.
  task automatic access(input int k, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string tag);
    int lat, cs_cycles, lat_exp, cs_exp, wt;
    bit addr_ok, wdata_ok;
    wt = wait_of(k);
    @(negedge CLK);
    req[k] = 1'b1; req_we[k] = w; req_addr[k] = a; req_wdata[k] = d;
    @(posedge CLK); #1;
    req[k] = 1'b0;
    check({tag, ".busy"}, busy[k], 1'b1);
    check({tag, ".cs"}, cs[k], 1'b1);
    lat = 0; cs_cycles = 0; addr_ok = 1'b1; wdata_ok = 1'b1;
    while (!done[k] && lat < 100) begin
      if (cs[k]) begin
        cs_cycles++;
        if (addr[k] !== a) addr_ok = 1'b0;
        if (we[k] && bus_v[k] !== d) wdata_ok = 1'b0;
      end
      @(posedge CLK); #1;
      lat++;
    end
    if (w) begin
      model[k][a] = stuck0 ? (d & ~32'd1) : d;
      if (VFY) last_rd[k] = model[k][a];
      lat_exp = VFY ? 3 + 2 * wt : 2 + wt;
      cs_exp  = VFY ? 2 + 2 * wt : 1 + wt;
    end else begin
      last_rd[k] = model[k][a];
      lat_exp = 1 + wt;
      cs_exp  = 1 + wt;
    end
    check({tag, ".done"}, done[k], 1'b1);
    check({tag, ".latency"}, 32'(lat), 32'(lat_exp));
    check({tag, ".cs_cycles"}, 32'(cs_cycles), 32'(cs_exp));
    check({tag, ".addr_stable"}, addr_ok, 1'b1);
    check({tag, ".wdata_on_bus"}, wdata_ok, 1'b1);
    check({tag, ".busy_end"}, busy[k], 1'b0);
    check({tag, ".rdata"}, rdata[k], last_rd[k]);
  endtask

  initial begin
    int n_done, bad;
    logic [DW-1:0] v;
    for (int k = 0; k < NDUT; k++) begin
      req[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
      last_rd[k] = '0;
      for (int a = 0; a < 128; a++) begin
        v = $urandom;
        model[k][a] = v;
      end
    end
    model[0][7'h10] = 32'h2002000A;
    model[1][7'h01] = 32'h12345678;
    load_ram = 1'b1;
    @(negedge CLK); #1 load_ram = 1'b0;
    @(negedge CLK);

    // Reset state
    for (int k = 0; k < NDUT; k++) begin
      check("rst.cs", cs[k], 1'b0);     check("rst.we", we[k], 1'b0);
      check("rst.addr", addr[k], '0);   check("rst.busy", busy[k], 1'b0);
      check("rst.done", done[k], 1'b0); check("rst.rdata", rdata[k], '0);
      check("rst.err", err[k], 1'b0);
    end
    RST_N = 1'b1;

    // Plain read, no wait states
    access(0, 1'b0, 7'h10, '0, "rd_nowait");
    check("rd_nowait.value", rdata[0], 32'h2002000A);

    // Write then read on the first legal edge
    access(0, 1'b1, 7'h7F, 32'hDEADBEEF, "wr_7f");
    access(0, 1'b0, 7'h7F, '0, "rd_7f");
    check("rd_7f.value", rdata[0], 32'hDEADBEEF);

    // Wait states
    access(1, 1'b0, 7'h01, '0, "rd_wait3");
    check("rd_wait3.value", rdata[1], 32'h12345678);

    // Second REQ while busy is ignored
    @(negedge CLK);
    req[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 7'h21;
    @(posedge CLK); #1;
    req_addr[1] = 7'h22;
    n_done = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (cs[1] && addr[1] !== 7'h21) bad++;
      if (done[1]) n_done++;
      if (i == 3) req[1] = 1'b0;
      @(posedge CLK); #1;
    end
    last_rd[1] = model[1][7'h21];
    check("busy_req.done_count", 32'(n_done), 32'd1);
    check("busy_req.wrong_addr", 32'(bad), 32'd0);
    check("busy_req.rdata", rdata[1], last_rd[1]);

    // REQ held high: back-to-back reads, DONE every other cycle
    @(negedge CLK);
    req[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 7'h10;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (done[0]) n_done++;
    end
    req[0] = 1'b0;
    last_rd[0] = model[0][7'h10];
    check("b2b.done_count", 32'(n_done), 32'd3);
    check("b2b.rdata", rdata[0], last_rd[0]);
    @(posedge CLK); #1;
    check("b2b.done_pulse", done[0], 1'b0);
    check("b2b.idle", busy[0], 1'b0);

    // Randomized traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      int k;
      bit w;
      logic [AW-1:0] a;
      k = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom);
      v = $urandom;
      access(k, w, a, v, w ? "rand_wr" : "rand_rd");
    end

    // Reset in the middle of a write, before the memory's negedge
    @(negedge CLK);
    req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 7'h05; req_wdata[0] = ~model[0][7'h05];
    @(posedge CLK); #1;
    req[0] = 1'b0;
    check("rst_mid.cs_before", cs[0], 1'b1);
    check("rst_mid.we_before", we[0], 1'b1);
    check("rst_mid.addr_before", addr[0], 7'h05);
    #1 RST_N = 1'b0;
    #1;
    check("rst_mid.cs", cs[0], 1'b0);
    check("rst_mid.we", we[0], 1'b0);
    check("rst_mid.busy", busy[0], 1'b0);
    n_done = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (done[0] || done[1]) n_done++;
    end
    check("rst_mid.no_done", 32'(n_done), 32'd0);
    check("rst_mid.rdata1", rdata[1], '0);
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge CLK); RST_N = 1'b1;
    access(0, 1'b0, 7'h05, '0, "rst_mid.ram5");

`ifdef MEM_BUS_READBACK_VERIFY_EN
    check("vfy.err_clean0", err[0], 1'b0);
    check("vfy.err_clean1", err[1], 1'b0);
    stuck0 = 1'b1;
    access(0, 1'b1, 7'h03, 32'hA5A5A5A5, "vfy_bad");
    check("vfy_bad.value", rdata[0], 32'hA5A5A5A4);
    check("vfy_bad.err", err[0], 1'b1);
    stuck0 = 1'b0;
    access(0, 1'b1, 7'h09, 32'h13579BDF, "vfy_good");
    check("vfy_good.err_sticky", err[0], 1'b1);
    check("vfy_good.err_other", err[1], 1'b0);
`else
    check("noverify.err0", err[0], 1'b0);
    check("noverify.err1", err[1], 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
